// File: rtl/cmp_flag_filter.sv
// cmp_flag_filter: debounces comparator relation flags into a registered relation with error flag and event counters.
// Optional saturating event counters are built when CMP_FLAG_FILTER_CNT_EN is defined.
module cmp_flag_filter #(
  parameter int STABLE_CNT = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             a_grt_b,
  input  logic             a_less_b,
  input  logic             a_eq_b,
  input  logic             clr,
  output logic [1:0]       rel,
  output logic             rel_valid,
  output logic             rel_change,
  output logic             err,
  output logic [CNT_W-1:0] grt_cnt,
  output logic [CNT_W-1:0] less_cnt,
  output logic [CNT_W-1:0] eq_cnt
);
  typedef enum logic [1:0] {IDLE, QUAL, LOCKED} state_t;
  localparam logic [1:0] EQ = 2'b00, LESS = 2'b01, GRT = 2'b10;
  state_t state_q, state_d;
  logic [1:0] cand_q, cand_d, rel_q, rel_d, s;
  logic [3:0] run_q, run_d;
  logic rel_valid_q, rel_change_q, err_q, err_d;
  logic onehot, legal, illegal, start, back, stay, inc, conf;
  assign s = {a_grt_b, a_less_b};
  assign onehot = (a_grt_b ^ a_less_b ^ a_eq_b) & ~(a_grt_b & a_less_b & a_eq_b);
  assign legal = in_valid & onehot;
  assign illegal = in_valid & ~onehot;
  always_comb begin
    start = legal && (state_q == IDLE || (state_q == LOCKED && s != rel_q) ||
            (state_q == QUAL && s != cand_q && !(rel_valid_q && s == rel_q)));
    back = legal && state_q == QUAL && s != cand_q && rel_valid_q && s == rel_q;
    stay = legal && state_q == LOCKED && s == rel_q;
    inc = legal && state_q == QUAL && s == cand_q;
    conf = (start && STABLE_CNT == 1) || (inc && run_q == 4'(STABLE_CNT - 1));
    cand_d = illegal ? 2'b00 : start ? s : cand_q;
    run_d = (illegal || back || stay || conf) ? 4'd0 : start ? 4'd1 : inc ? run_q + 4'd1 : run_q;
    state_d = conf ? LOCKED : illegal ? (rel_valid_q ? LOCKED : IDLE) :
              start ? QUAL : back ? LOCKED : state_q;
    rel_d = conf ? s : rel_q;
    // an illegal sample in the same cycle as clr leaves err set
    err_d = (err_q & ~clr) | illegal;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q <= 2'b00;
      run_q <= 4'd0;
      rel_q <= EQ;
      rel_valid_q <= 1'b0;
      rel_change_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      run_q <= run_d;
      rel_q <= rel_d;
      rel_valid_q <= rel_valid_q | conf;
      rel_change_q <= conf;
      err_q <= err_d;
    end
  end
  assign rel = rel_q;
  assign rel_valid = rel_valid_q;
  assign rel_change = rel_change_q;
  assign err = err_q;
`ifdef CMP_FLAG_FILTER_CNT_EN
  logic [CNT_W-1:0] grt_q, less_q, eq_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      grt_q <= '0;
      less_q <= '0;
      eq_q <= '0;
    end else begin
      if (conf && rel_d == GRT && ~&grt_q) grt_q <= grt_q + 1'b1;
      if (conf && rel_d == LESS && ~&less_q) less_q <= less_q + 1'b1;
      if (conf && rel_d == EQ && ~&eq_q) eq_q <= eq_q + 1'b1;
    end
  end
  assign grt_cnt = grt_q;
  assign less_cnt = less_q;
  assign eq_cnt = eq_q;
`else
  assign grt_cnt = '0;
  assign less_cnt = '0;
  assign eq_cnt = '0;
`endif
endmodule

// File: tb/tb_cmp_flag_filter.sv
// tb_cmp_flag_filter: directed checks of debouncing, gaps, errors, saturation and async reset.
module tb_cmp_flag_filter;
  localparam int CW = 2;
`ifdef CMP_FLAG_FILTER_CNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  logic clk = 0, rst = 1, in_valid = 0, g = 0, l = 0, e = 0, clr = 0;
  logic [1:0] rel;
  logic rel_valid, rel_change, err;
  logic [CW-1:0] grt_cnt, less_cnt, eq_cnt;
  int vectors = 0, miscompares = 0;
  cmp_flag_filter #(.STABLE_CNT(3), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a_grt_b(g), .a_less_b(l), .a_eq_b(e),
    .clr(clr), .rel(rel), .rel_valid(rel_valid), .rel_change(rel_change), .err(err),
    .grt_cnt(grt_cnt), .less_cnt(less_cnt), .eq_cnt(eq_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [2:0] f, input logic c);
    @(negedge clk);
    in_valid = v; {g, l, e} = f; clr = c;
    @(posedge clk); #1;
    in_valid = 0; clr = 0;
  endtask
  task automatic outs(input string tag, input logic [1:0] r, input logic rv, input logic rc, input logic er);
    chk({tag, ".rel"}, 8'(rel), 8'(r));
    chk({tag, ".rel_valid"}, 8'(rel_valid), 8'(rv));
    chk({tag, ".rel_change"}, 8'(rel_change), 8'(rc));
    chk({tag, ".err"}, 8'(err), 8'(er));
  endtask
  task automatic cnts(input string tag, input int gc, input int lc, input int ec);
    chk({tag, ".grt_cnt"}, 8'(grt_cnt), CE ? 8'(gc) : 8'd0);
    chk({tag, ".less_cnt"}, 8'(less_cnt), CE ? 8'(lc) : 8'd0);
    chk({tag, ".eq_cnt"}, 8'(eq_cnt), CE ? 8'(ec) : 8'd0);
  endtask
  localparam logic [2:0] G = 3'b100, L = 3'b010, E = 3'b001;
  initial begin
    #12;
    outs("reset", 2'b00, 0, 0, 0);
    cnts("reset", 0, 0, 0);
    @(negedge clk); rst = 0;
    step(1, G, 0); outs("grt1", 2'b00, 0, 0, 0);
    step(1, G, 0); outs("grt2", 2'b00, 0, 0, 0);
    step(1, G, 0); outs("grt3", 2'b10, 1, 1, 0); cnts("grt3", 1, 0, 0);
    step(0, 3'b000, 0); outs("grt_hold", 2'b10, 1, 0, 0);
    step(1, L, 0); step(1, L, 0); outs("ll", 2'b10, 1, 0, 0);
    step(1, G, 0); outs("llg", 2'b10, 1, 0, 0);
    step(1, L, 0); step(1, L, 0); outs("llgll", 2'b10, 1, 0, 0);
    step(1, L, 0); outs("less3", 2'b01, 1, 1, 0); cnts("less3", 1, 1, 0);
    step(1, E, 0); step(0, E, 0); step(0, E, 0); step(1, E, 0); step(0, E, 0);
    outs("eq_gap", 2'b01, 1, 0, 0);
    step(1, E, 0); outs("eq3", 2'b00, 1, 1, 0); cnts("eq3", 1, 1, 1);
    step(1, G, 0); step(1, G, 0);
    step(1, G | E, 0); outs("illegal", 2'b00, 1, 0, 1);
    step(1, G, 0); step(1, G, 0); outs("restart", 2'b00, 1, 0, 1);
    step(1, G, 0); outs("grt_again", 2'b10, 1, 1, 1); cnts("grt_again", 2, 1, 1);
    step(0, 3'b000, 1); outs("clr", 2'b10, 1, 0, 0); cnts("clr", 0, 0, 0);
    step(1, 3'b000, 0); outs("zero_flags", 2'b10, 1, 0, 1);
    step(1, G | L | E, 1); outs("clr_vs_err", 2'b10, 1, 0, 1);
    step(0, 3'b000, 1);
    for (int i = 0; i < 4; i++) begin
      repeat (3) step(1, E, 0);
      repeat (3) step(1, G, 0);
    end
    outs("sat", 2'b10, 1, 1, 0); cnts("sat", 3, 0, 3);
    step(1, E, 0); step(1, E, 0);
    step(1, E, 1); outs("clr_conf", 2'b00, 1, 1, 0); cnts("clr_conf", 0, 0, 0);
    step(1, G, 0); step(1, G, 0);
    @(negedge clk); #2 rst = 1; #1;
    outs("async_rst", 2'b00, 0, 0, 0); cnts("async_rst", 0, 0, 0);
    @(negedge clk); rst = 0;
    step(1, G, 0); step(1, G, 0); outs("fresh2", 2'b00, 0, 0, 0);
    step(1, G, 0); outs("fresh3", 2'b10, 1, 1, 0); cnts("fresh3", 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
